seg_digit_buffer: RTL

//  Parametrised N-digit entry buffer between the keypad decoder and the multiplexed

---
 rtl/seg_digit_buffer_if.sv | 23 ++
 rtl/seg_digit_buffer.sv | 69 ++++++
 2 files changed

// File: rtl/seg_digit_buffer_if.sv
// seg_digit_buffer_if: keypad-side entry controls and display-side digit outputs; blank vector present only with SEG_DIGIT_BLANK_EN
interface seg_digit_buffer_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4
);
    localparam int CW = $clog2(NUM_DIGITS + 1);
    logic                          new_hex;
    logic [DIGIT_W-1:0]            hex_new;
    logic                          backspace;
    logic                          clear;
    logic [NUM_DIGITS*DIGIT_W-1:0] digits;
    logic [CW-1:0]                 count;
    logic                          full;
    logic                          accepted;
`ifdef SEG_DIGIT_BLANK_EN
    logic [NUM_DIGITS-1:0]         blank;
    modport master (output new_hex, hex_new, backspace, clear, input digits, count, full, accepted, blank);
    modport slave  (input new_hex, hex_new, backspace, clear, output digits, count, full, accepted, blank);
`else
    modport master (output new_hex, hex_new, backspace, clear, input digits, count, full, accepted);
    modport slave  (input new_hex, hex_new, backspace, clear, output digits, count, full, accepted);
`endif
endinterface

// File: rtl/seg_digit_buffer.sv
// seg_digit_buffer: N-digit shift-in entry buffer with edge-detected push/backspace, clear, count and full; SEG_DIGIT_BLANK_EN adds a blank mask
module seg_digit_buffer #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4
) (
    input logic             clk,
    input logic             reset,
    seg_digit_buffer_if.slave bus
);
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int DW = NUM_DIGITS * DIGIT_W;
    logic [DW-1:0] digits_q, digits_d;
    logic [CW-1:0] count_q, count_d;
    logic          accepted_q, accepted_d;
    logic          new_hex_q, backspace_q;
    logic          push_ev, bs_ev;
    assign push_ev = bus.new_hex & ~new_hex_q;
    assign bs_ev   = bus.backspace & ~backspace_q;
    // next state with priority clear > push > backspace; holds when nothing happens
    always_comb begin
        digits_d   = digits_q;
        count_d    = count_q;
        accepted_d = 1'b0;
        if (bus.clear) begin
            digits_d = '0;
            count_d  = '0;
        end else if (push_ev) begin
            digits_d   = {digits_q[DW-DIGIT_W-1:0], bus.hex_new};
            count_d    = (count_q == CW'(NUM_DIGITS)) ? count_q : count_q + CW'(1);
            accepted_d = 1'b1;
        end else if (bs_ev && count_q != '0) begin
            digits_d   = {{DIGIT_W{1'b0}}, digits_q[DW-1:DIGIT_W]};
            count_d    = count_q - CW'(1);
            accepted_d = 1'b1;
        end
    end
`ifdef SEG_DIGIT_BLANK_EN
    logic [NUM_DIGITS-1:0] blank_q, blank_d;
    // digits at or above the new count have not been entered yet
    always_comb begin
        blank_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) blank_d[i] = CW'(i) >= count_d;
    end
    // blank mask tracks count; everything blanked out of reset
    always_ff @(posedge clk) begin
        if (reset) blank_q <= '1;
        else       blank_q <= blank_d;
    end
    assign bus.blank = blank_q;
`endif
    // state registers; edge registers follow the inputs even in reset so a held key does not fire afterwards
    always_ff @(posedge clk) begin
        new_hex_q   <= bus.new_hex;
        backspace_q <= bus.backspace;
        if (reset) begin
            digits_q   <= '0;
            count_q    <= '0;
            accepted_q <= 1'b0;
        end else begin
            digits_q   <= digits_d;
            count_q    <= count_d;
            accepted_q <= accepted_d;
        end
    end
    assign bus.digits   = digits_q;
    assign bus.count    = count_q;
    assign bus.full     = count_q == CW'(NUM_DIGITS);
    assign bus.accepted = accepted_q;
endmodule
